// File: rtl/modulator_pam_pkg.sv
// Shared definitions for the PAM-4 modulator.
//   state_e       : top-level FSM states
//   sym_level     : 2-bit symbol to DAC level (L1 = L3/3, L3 = full scale)
//   params_legal  : elaboration-time sanity check of the block parameters
package modulator_pam_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StRun} state_e;

  // Level is returned 32 bits wide; callers take the low `width` bits.
  function automatic logic [31:0] sym_level(input logic [1:0] sym, input int unsigned width);
    logic [31:0] l3;
    logic [31:0] l1;
    l3 = (32'd1 << width) - 32'd1;
    l1 = l3 / 32'd3;
    case (sym)
      2'b00:   sym_level = 32'd0;
      2'b01:   sym_level = l1;
      2'b10:   sym_level = l1 << 1;
      default: sym_level = l3;
    endcase
  endfunction

  // Symbol period must hold a whole frame plus the prefetch/capture slack.
  function automatic bit params_legal(input int unsigned sym_period,
                                      input int unsigned code_bits,
                                      input int unsigned frame_bits);
    params_legal = (code_bits >= 1) && (code_bits <= 31) && (frame_bits >= code_bits) &&
                   (sym_period >= 2 * frame_bits + 4);
  endfunction

endpackage

// File: rtl/modulator_pam_dac_serializer.sv
// Serial DAC frame generator.
//   clk, rst : clock, async active-low reset
//   start    : one-cycle pulse, loads word; frame begins on the next cycle
//   word     : frame word, sent MSB first
//   pwm      : serial data, each bit held for one bclk period (2 clk)
//   nsync    : frame sync, low for 2*FrameBits cycles
//   bclk     : clk/2 during the frame (high on even cycles), idle high
module modulator_pam_dac_serializer #(
  parameter int unsigned FrameBits = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [FrameBits-1:0] word,
  output logic                 pwm,
  output logic                 nsync,
  output logic                 bclk
);

  localparam int unsigned CntW = $clog2(2 * FrameBits);
  localparam logic [CntW-1:0] CntLast = CntW'(2 * FrameBits - 1);

  logic [CntW-1:0]      cnt_q;
  logic                 active_q;
  logic [FrameBits-1:0] sh_q;
  logic                 nsync_q;
  logic                 bclk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      sh_q     <= '0;
      nsync_q  <= 1'b1;
      bclk_q   <= 1'b1;
    end else if (start) begin
      cnt_q    <= '0;
      active_q <= 1'b1;
      sh_q     <= word;
      nsync_q  <= 1'b0;
      bclk_q   <= 1'b1;
    end else if (active_q) begin
      // Shift after the bclk-low cycle; after the last bit the register is all zero,
      // which leaves pwm low between frames.
      if (cnt_q[0]) sh_q <= sh_q << 1;
      if (cnt_q == CntLast) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
        nsync_q  <= 1'b1;
        bclk_q   <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        bclk_q <= cnt_q[0];
      end
    end
  end

  assign pwm   = sh_q[FrameBits-1];
  assign nsync = nsync_q;
  assign bclk  = bclk_q;

endmodule

// File: rtl/modulator_pam.sv
// Baseband PAM-4 modulator: fetches bytes from a FIFO, sends four 2-bit symbols per byte
// (bits 7:6 first), one serial DAC frame per symbol period.
//   clk, rst  : clock, async active-low reset
//   enable    : run enable
//   sample    : FIFO read data, valid the cycle after read
//   empty     : FIFO empty flag
//   read      : FIFO read strobe
//   pwm       : DAC serial data
//   nsync     : DAC frame sync, active low
//   bclk      : DAC bit clock
//   symb_clk  : symbol-rate strobe, high for the first half of each symbol in RUN
module modulator_pam
  import modulator_pam_pkg::*;
#(
  parameter int unsigned PARAMETER01 = 1200,
  parameter int unsigned PARAMETER02 = 12,
  parameter int unsigned PARAMETER03 = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] sample,
  input  logic       empty,
  output logic       read,
  output logic       pwm,
  output logic       nsync,
  output logic       bclk,
  output logic       symb_clk
);

  if (!params_legal(PARAMETER01, PARAMETER02, PARAMETER03)) begin : g_param_check
    $error("modulator_pam: illegal parameter combination");
  end

  localparam int unsigned ScW = $clog2(PARAMETER01);
  localparam logic [ScW-1:0] ScLast     = ScW'(PARAMETER01 - 1);
  localparam logic [ScW-1:0] ScCapture  = ScW'(PARAMETER01 - 2);
  localparam logic [ScW-1:0] ScPrefetch = ScW'(PARAMETER01 - 3);
  localparam logic [ScW-1:0] ScHalf     = ScW'(PARAMETER01 / 2);

  localparam logic [PARAMETER02-1:0] Lvl0 = PARAMETER02'(sym_level(2'd0, PARAMETER02));
  localparam logic [PARAMETER02-1:0] Lvl1 = PARAMETER02'(sym_level(2'd1, PARAMETER02));
  localparam logic [PARAMETER02-1:0] Lvl2 = PARAMETER02'(sym_level(2'd2, PARAMETER02));
  localparam logic [PARAMETER02-1:0] Lvl3 = PARAMETER02'(sym_level(2'd3, PARAMETER02));

  state_e           state_q;
  logic [ScW-1:0]   sc_q;
  logic [1:0]       si_q;
  logic [7:0]       byte_q;
  logic             pf_q;    // next byte already read at the prefetch point

  logic             sym_end;
  logic             prefetch;
  logic             cont;
  logic             start;
  logic [1:0]       nsi;
  logic [1:0]       sym;
  logic [PARAMETER02-1:0] level;
  logic [PARAMETER03-1:0] word;

  assign sym_end  = (state_q == StRun) && (sc_q == ScLast);
  assign prefetch = (state_q == StRun) && (si_q == 2'd3) && (sc_q == ScPrefetch) &&
                    enable && !empty;
  assign cont     = enable && ((si_q != 2'd3) || pf_q);
  assign nsi      = si_q + 2'd1;

  assign read     = (state_q == StFetch) || prefetch;
  assign symb_clk = (state_q == StRun) && (sc_q < ScHalf);

  // The serializer is started one cycle ahead of sc=0 so its registered outputs line
  // up with the symbol. On the first symbol the byte is still on the FIFO bus.
  always_comb begin
    start = 1'b0;
    sym   = 2'b00;
    if (state_q == StLoad) begin
      start = 1'b1;
      sym   = sample[7:6];
    end else if (sym_end && cont) begin
      start = 1'b1;
      case (nsi)
        2'd0:    sym = byte_q[7:6];
        2'd1:    sym = byte_q[5:4];
        2'd2:    sym = byte_q[3:2];
        default: sym = byte_q[1:0];
      endcase
    end
  end

  always_comb begin
    case (sym)
      2'b00:   level = Lvl0;
      2'b01:   level = Lvl1;
      2'b10:   level = Lvl2;
      default: level = Lvl3;
    endcase
    word = PARAMETER03'(level);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sc_q    <= '0;
      si_q    <= '0;
      byte_q  <= '0;
      pf_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable && !empty) state_q <= StFetch;
        end
        StFetch: state_q <= StLoad;
        StLoad: begin
          byte_q  <= sample;
          sc_q    <= '0;
          si_q    <= '0;
          pf_q    <= 1'b0;
          state_q <= StRun;
        end
        StRun: begin
          if (prefetch) pf_q <= 1'b1;
          if (pf_q && (sc_q == ScCapture)) byte_q <= sample;
          if (sc_q == ScLast) begin
            sc_q <= '0;
            pf_q <= 1'b0;
            if (cont) begin
              si_q <= nsi;
            end else begin
              si_q    <= '0;
              state_q <= StIdle;
            end
          end else begin
            sc_q <= sc_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  modulator_pam_dac_serializer #(
    .FrameBits(PARAMETER03)
  ) u_dac_serializer (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .word (word),
    .pwm  (pwm),
    .nsync(nsync),
    .bclk (bclk)
  );

endmodule

// File: tb/tb_modulator_pam.sv
module tb_modulator_pam;

  localparam int unsigned P1 = 1200;
  localparam int unsigned P2 = 12;
  localparam int unsigned P3 = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] sample = 8'h00;
  logic       empty = 1'b1;
  logic       read, pwm, nsync, bclk, symb_clk;

  always #5 clk = ~clk;

  modulator_pam #(
    .PARAMETER01(P1),
    .PARAMETER02(P2),
    .PARAMETER03(P3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .sample  (sample),
    .empty   (empty),
    .read    (read),
    .pwm     (pwm),
    .nsync   (nsync),
    .bclk    (bclk),
    .symb_clk(symb_clk)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: symbol i of byte b is bits [7-2i:6-2i]; levels 0, L1, 2*L1, L3.
  function automatic logic [15:0] ref_word(input logic [7:0] b, input int i);
    int s;
    int l3;
    int l1;
    s  = (int'(b) >> (6 - 2 * i)) & 3;
    l3 = (1 << P2) - 1;
    l1 = l3 / 3;
    ref_word = (s == 3) ? 16'(l3) : 16'(s * l1);
  endfunction

  typedef struct packed {
    logic [7:0]       b;
    logic [3:0][15:0] w;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [15:0] w2,
                              input logic [15:0] w3);
    mk.b    = b;
    mk.w[0] = w0;
    mk.w[1] = w1;
    mk.w[2] = w2;
    mk.w[3] = w3;
  endfunction

  // FIFO model and expected frame words
  logic [7:0]  fifo[$];
  logic [15:0] exp_q[$];
  logic        hold_empty = 1'b0;
  logic        rd_seen = 1'b0;
  int          underflow = 0;

  task automatic push_tbl(input vec_t v);
    fifo.push_back(v.b);
    for (int i = 0; i < 4; i++) exp_q.push_back(v.w[i]);
  endtask

  task automatic push_rand(input logic [7:0] b);
    fifo.push_back(b);
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_word(b, i));
  endtask

  always @(negedge clk) rd_seen = read;

  always @(posedge clk) begin
    #1;
    if (rd_seen && rst) begin
      if (fifo.size() > 0) sample = fifo.pop_front();
      else underflow++;
    end
    empty = hold_empty || (fifo.size() == 0);
  end

  // Monitor: decodes DAC frames and checks framing/timing
  longint cyc = 0;
  longint last_read = -100;
  longint last_fall = 0;
  bit     have_fall = 0;
  longint reads[$];
  int     n_reads = 0;
  int     frames_seen = 0;
  int     nlow = 0;
  int     idle_bad = 0;
  int     unstable = 0;
  int     shigh = 0;
  logic   nsync_p = 1'b1;
  logic   hold_bit = 1'b0;
  logic [15:0] word = '0;
  logic [16:0] exp_w;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      have_fall = 0;
      nlow      = 0;
      shigh     = 0;
      nsync_p   = 1'b1;
    end else begin
      if (read === 1'b1) begin
        reads.push_back(cyc);
        last_read = cyc;
        n_reads++;
      end
      if (nsync === 1'b0) begin
        if (nsync_p) begin
          chk("frame_start_timing",
              ((have_fall && (cyc - last_fall == P1)) || (cyc - last_read == 2)) ? 1 : 0, 1);
          have_fall = 1;
          last_fall = cyc;
          nlow      = 0;
          word      = '0;
        end
        nlow++;
        if (bclk === 1'b1) hold_bit = pwm;
        else begin
          word = {word[14:0], pwm};
          if (pwm !== hold_bit) unstable++;
        end
      end else begin
        if (nsync_p === 1'b0) begin
          frames_seen++;
          chk("nsync_low_len", nlow, 2 * P3);
          exp_w = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 17'h1_0000;
          chk("frame_word", word, exp_w);
        end
        if (bclk !== 1'b1 || pwm !== 1'b0) idle_bad++;
      end
      if (symb_clk === 1'b1) shigh++;
      else if (shigh > 0) begin
        chk("symb_clk_high", shigh, P1 / 2);
        shigh = 0;
      end
      nsync_p = nsync;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || nsync !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frames_in_time", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic chk_intervals(input string name);
    for (int i = 1; i < reads.size(); i++)
      chk(name, reads[i] - reads[i-1], (i == 1) ? 4 * P1 - 1 : 4 * P1);
  endtask

  initial begin
    #(950_000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  vec_t tbl [4];
  int   base_f;
  int   base_r;
  int   n;

  initial begin
    tbl[0] = mk(8'hAA, 16'h0AAA, 16'h0AAA, 16'h0AAA, 16'h0AAA);
    tbl[1] = mk(8'hAA, 16'h0AAA, 16'h0AAA, 16'h0AAA, 16'h0AAA);
    tbl[2] = mk(8'h1B, 16'h0000, 16'h0555, 16'h0AAA, 16'h0FFF);
    tbl[3] = mk(8'hE4, 16'h0FFF, 16'h0AAA, 16'h0555, 16'h0000);

    // Reset values
    #1 rst = 1'b0;
    wait_cycles(5);
    chk("rst_read", read, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_nsync", nsync, 1);
    chk("rst_bclk", bclk, 1);
    chk("rst_symb_clk", symb_clk, 0);

    // Table vectors back to back, including steady-state read spacing
    for (int k = 0; k < 4; k++) push_tbl(tbl[k]);
    wait_cycles(2);
    enable = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    wait_drain(25000);
    wait_cycles(1300);
    chk("tbl_reads", n_reads, 4);
    chk_intervals("tbl_read_period");

    // Empty at the prefetch point: one byte only, then idle; later restart
    reads.delete();
    base_r = n_reads;
    base_f = frames_seen;
    push_rand(8'h6C);
    wait_drain(8000);
    wait_cycles(2500);
    chk("empty_no_prefetch_read", n_reads - base_r, 1);
    chk("empty_frames", frames_seen - base_f, 4);
    push_rand(8'h93);
    wait_drain(8000);
    wait_cycles(1300);
    chk("restart_reads", n_reads - base_r, 2);

    // Random bytes; an empty glitch between sample points must be ignored
    reads.delete();
    base_r = n_reads;
    base_f = frames_seen;
    for (int k = 0; k < 4; k++) push_rand(8'($urandom_range(0, 255)));
    wait_frames(base_f + 1, 3000);
    hold_empty = 1'b1;
    wait_cycles(300);
    hold_empty = 1'b0;
    wait_drain(25000);
    wait_cycles(1300);
    chk("rand_reads", n_reads - base_r, 4);
    chk_intervals("rand_read_period");

    // enable=0 mid-byte: current symbol completes, nothing further
    base_r = n_reads;
    base_f = frames_seen;
    push_rand(8'h27);
    fifo.push_back(8'hD8);
    wait_frames(base_f + 2, 4000);
    enable = 1'b0;
    exp_q.delete();
    wait_cycles(6000);
    chk("dis_frames", frames_seen - base_f, 2);
    chk("dis_reads", n_reads - base_r, 1);
    chk("dis_fifo_left", fifo.size(), 1);
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_word(8'hD8, i));
    enable = 1'b1;
    wait_drain(8000);
    wait_cycles(1300);
    chk("reen_reads", n_reads - base_r, 2);

    // Reset mid-frame
    base_f = frames_seen;
    push_rand(8'h5A);
    wait_frames(base_f + 1, 4000);
    n = 0;
    while (nsync !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("second_frame_started", (n < 2000) ? 1 : 0, 1);
    wait_cycles(10);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_read", read, 0);
    chk("mid_rst_pwm", pwm, 0);
    chk("mid_rst_nsync", nsync, 1);
    chk("mid_rst_bclk", bclk, 1);
    chk("mid_rst_symb_clk", symb_clk, 0);
    exp_q.delete();
    fifo.delete();
    wait_cycles(5);
    base_r = n_reads;
    push_rand(8'hC3);
    wait_cycles(2);
    #2 rst = 1'b1;
    wait_drain(8000);
    wait_cycles(1300);
    chk("post_rst_reads", n_reads - base_r, 1);

    chk("exp_left", exp_q.size(), 0);
    chk("idle_lines", idle_bad, 0);
    chk("pwm_stable_bclk_low", unstable, 0);
    chk("fifo_underflow", underflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
